// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, frame levels and the receiver state encoding.
package uart_pkg;

    // 50 MHz clock, 115200 baud
    localparam int unsigned CLKDIV_DEFAULT = 50000000 / 115200 - 1;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam logic        IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset level.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a divider count, one-cycle valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKDIV = CLKDIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] DIV_FULL = 16'(CLKDIV);
    localparam logic [15:0] DIV_HALF = 16'(CLKDIV / 2);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t   state;
    logic        rxs;
    logic [15:0] divcntr;
    logic [2:0]  bitcnt;
    logic [7:0]  shift;

    uart_rx_sync #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (rx_serial),
        .dout(rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            divcntr   <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxs == START_LEVEL) begin
                        state   <= START;
                        divcntr <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (divcntr == DIV_HALF) begin
                        if (rxs == START_LEVEL) begin
                            state   <= DATA;
                            divcntr <= '0;
                            bitcnt  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        divcntr <= divcntr + 16'd1;
                    end
                end
                DATA: begin
                    if (divcntr == DIV_FULL) begin
                        shift[bitcnt] <= rxs;
                        divcntr       <= '0;
                        bitcnt        <= bitcnt + 3'd1;
                        if (bitcnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        divcntr <= divcntr + 16'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit keeps half a bit of slack for the next start edge
                    if (divcntr == DIV_FULL) begin
                        if (rxs == STOP_LEVEL) begin
                            dout  <= shift;
                            valid <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        divcntr <= divcntr + 16'd1;
                    end
                end
                BREAK: begin
                    if (rxs == IDLE_LEVEL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table and corner sequences at CLKDIV=433, randomized scoreboard run at CLKDIV=9.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned DIV_A = 433;
    localparam int unsigned DIV_B = 9;
    localparam int BIT_A = 434;
    localparam int BIT_B = 10;
    localparam int BIT_FAST = 425;
    localparam int BIT_SLOW = 443;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rx_a, rx_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

    uart_rx #(.CLKDIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst_a), .rx_serial(rx_a),
        .dout(dout_a), .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx #(.CLKDIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst_b), .rx_serial(rx_b),
        .dout(dout_b), .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       ferr;
        logic [7:0] d;
    } ev_t;

    int         va_cnt = 0;
    int         fa_cnt = 0;
    logic [7:0] va_q[$];
    ev_t        obs_b[$];
    ev_t        exp_b[$];

    always @(negedge clk) begin
        if (valid_a) begin
            va_cnt++;
            va_q.push_back(dout_a);
        end
        if (ferr_a) fa_cnt++;
        if (valid_a || ferr_a) check("exclusive_a", {31'b0, valid_a & ferr_a}, 32'd0);
        if (valid_b) obs_b.push_back({1'b0, dout_b});
        if (ferr_b) obs_b.push_back({1'b1, dout_b});
        if (valid_b || ferr_b) check("exclusive_b", {31'b0, valid_b & ferr_b}, 32'd0);
    end

    task automatic send_a(input logic [7:0] d, input logic stop, input int bitc);
        rx_a = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            repeat (bitc) @(negedge clk);
        end
        rx_a = stop;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d, input logic stop);
        rx_b = 1'b0;
        repeat (BIT_B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_b = d[i];
            repeat (BIT_B) @(negedge clk);
        end
        rx_b = stop;
        repeat (BIT_B) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold_low;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[4];
        int         v0, f0, qs;
        logic [7:0] b2b[4];
        logic [7:0] got;
        logic [7:0] last_b;

        rx_a = 1'b1; rx_b = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        #2 rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout_a", dout_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_ferr_a", ferr_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_busy_b", busy_b, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (5) @(negedge clk);

        fork
            begin
                vecs[0] = '{8'hA5, 1'b1, 0,    1, 0, 8'hA5};
                vecs[1] = '{8'h3C, 1'b0, 2000, 0, 1, 8'hA5};
                vecs[2] = '{8'h00, 1'b1, 0,    1, 0, 8'h00};
                vecs[3] = '{8'hFF, 1'b0, 0,    0, 1, 8'h00};
                for (int k = 0; k < 4; k++) begin
                    v0 = va_cnt; f0 = fa_cnt;
                    send_a(vecs[k].data, vecs[k].stop, BIT_A);
                    if (vecs[k].hold_low > 0) begin
                        repeat (vecs[k].hold_low) @(negedge clk);
                        check("break_held_busy", busy_a, 1);
                    end
                    rx_a = 1'b1;
                    repeat (BIT_A) @(negedge clk);
                    check("vec_valid_count", va_cnt - v0, vecs[k].exp_valid);
                    check("vec_ferr_count", fa_cnt - f0, vecs[k].exp_ferr);
                    check("vec_dout", dout_a, vecs[k].exp_dout);
                    check("vec_idle_busy", busy_a, 0);
                end

                // low glitch shorter than half a bit
                v0 = va_cnt; f0 = fa_cnt;
                rx_a = 1'b0;
                repeat (2) @(negedge clk);
                check("glitch_busy_pre", busy_a, 0);
                repeat (1) @(negedge clk);
                check("glitch_busy_rise", busy_a, 1);
                repeat (97) @(negedge clk);
                rx_a = 1'b1;
                repeat (112) @(negedge clk);
                check("glitch_busy_hold", busy_a, 1);
                repeat (14) @(negedge clk);
                check("glitch_busy_fall", busy_a, 0);
                repeat (300) @(negedge clk);
                check("glitch_valid", va_cnt - v0, 0);
                check("glitch_ferr", fa_cnt - f0, 0);
                check("glitch_dout", dout_a, 8'h00);

                // back-to-back frames, sender fast then slow
                b2b[0] = 8'h55; b2b[1] = 8'hAA; b2b[2] = 8'h00; b2b[3] = 8'hFF;
                v0 = va_cnt; f0 = fa_cnt; qs = va_q.size();
                for (int k = 0; k < 4; k++) send_a(b2b[k], 1'b1, BIT_FAST);
                for (int k = 0; k < 4; k++) send_a(b2b[k], 1'b1, BIT_SLOW);
                rx_a = 1'b1;
                repeat (BIT_A) @(negedge clk);
                check("b2b_valid_count", va_cnt - v0, 8);
                check("b2b_ferr_count", fa_cnt - f0, 0);
                for (int k = 0; k < 8; k++) begin
                    got = (qs + k < va_q.size()) ? va_q[qs + k] : 8'hxx;
                    check("b2b_byte", got, b2b[k % 4]);
                end

                // reset in DATA bit 4 of 0x81
                v0 = va_cnt; f0 = fa_cnt;
                rx_a = 1'b0;
                repeat (BIT_A) @(negedge clk);
                rx_a = 1'b1;
                repeat (BIT_A) @(negedge clk);
                rx_a = 1'b0;
                repeat (4 * BIT_A + 200) @(negedge clk);
                check("rstmid_busy_pre", busy_a, 1);
                #3 rst_a = 1'b0;
                #1;
                check("rstmid_dout", dout_a, 0);
                check("rstmid_valid", valid_a, 0);
                check("rstmid_ferr", ferr_a, 0);
                check("rstmid_busy", busy_a, 0);
                @(negedge clk);
                rx_a = 1'b1;
                repeat (50) @(negedge clk);
                rst_a = 1'b1;
                repeat (20) @(negedge clk);
                check("rstmid_no_pulse", (va_cnt - v0) + (fa_cnt - f0), 0);
                send_a(8'h7E, 1'b1, BIT_A);
                repeat (BIT_A) @(negedge clk);
                check("after_rst_valid", va_cnt - v0, 1);
                check("after_rst_ferr", fa_cnt - f0, 0);
                check("after_rst_dout", dout_a, 8'h7E);
            end
            begin
                last_b = 8'h00;
                for (int i = 0; i < 256; i++) begin
                    exp_b.push_back({1'b0, 8'(i)});
                    last_b = 8'(i);
                    send_b(8'(i), 1'b1);
                end
                for (int i = 0; i < 60; i++) begin
                    logic [7:0] d;
                    logic       stop;
                    int         gap;
                    d    = 8'($urandom);
                    stop = ($urandom_range(0, 3) != 0);
                    gap  = stop ? $urandom_range(0, 25) : $urandom_range(5, 25);
                    if (stop) begin
                        exp_b.push_back({1'b0, d});
                        last_b = d;
                    end else begin
                        exp_b.push_back({1'b1, last_b});
                    end
                    send_b(d, stop);
                    rx_b = 1'b1;
                    repeat (gap) @(negedge clk);
                end
                repeat (5 * BIT_B) @(negedge clk);
                check("rand_event_count", obs_b.size(), exp_b.size());
                for (int i = 0; i < exp_b.size(); i++) begin
                    ev_t o;
                    o = (i < obs_b.size()) ? obs_b[i] : 9'hxxx;
                    check("rand_event", {23'b0, o}, {23'b0, exp_b[i]});
                end
                check("rand_final_dout", dout_b, last_b);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line.
- Recovers each byte by sampling at mid-bit from a clock-divider count.
- Presents the byte with a one-cycle strobe and flags framing errors.
- Sits between the board RX pin and the byte-consuming logic; it is the receive counterpart of the team's UART transmitter and uses the same bit-period parameter.

## Interface
- `CLKDIV`, default 50000000/115200-1 (433): bit period minus one, in clk cycles. Legal range 2..65535.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `rx_serial`  input  1  raw serial line, asynchronous to `clk`.
- `dout`  output  8  last correctly framed byte; held until the next good frame.
- `valid`  output  1  one-cycle pulse when `dout` is updated.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rx_serial` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized signal `rxs`.
- Bit counter `divcntr` is 16 bits wide. Data index `bitcnt` is 3 bits wide.
- State machine:
  - **IDLE**: on `rxs`=0, go to START with `divcntr`=0.
  - **START**: when `divcntr`==CLKDIV/2 (integer division), sample `rxs`.
    - If 0: reset `divcntr` to 0 and `bitcnt` to 0, then go to DATA.
    - If 1: glitch; go to IDLE with no output.
  - **DATA**: when `divcntr`==CLKDIV, sample `rxs` into shift register bit `bitcnt`, reset `divcntr` to 0, then increment `bitcnt`. After bit 7, go to STOP.
  - **STOP**: when `divcntr`==CLKDIV, sample `rxs`.
    - If 1: load `dout` with the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `dout` unchanged, go to BREAK.
  - **BREAK**: wait for `rxs`=1, then go to IDLE. This prevents a low line from re-triggering a start.
- Frame outcomes are exclusive: `valid` and `frame_err` are never high in the same cycle.
- No backpressure. The consumer must capture `dout` on `valid`. A new frame overwrites `dout` only on its own `valid`.

## Timing
- Reset values: `dout`=0, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE. Reset mid-frame aborts the frame immediately, with no pulse.
- Bit period is CLKDIV+1 cycles.
- Start-sample point: (CLKDIV/2)+1 cycles after IDLE sees `rxs` low. Each subsequent sample follows the previous one by CLKDIV+1 cycles.
- `valid`/`frame_err` fire on the cycle after the stop-bit sample.
  - Total latency from the line's falling edge to the pulse ≈ 2 (sync) + CLKDIV/2 + 9·(CLKDIV+1) + 1 cycles.
- Return to IDLE happens at mid-stop-bit. Back-to-back frames with a single stop bit are received with no gap loss, including under ±2% baud mismatch.
- `busy` rises the cycle after the falling edge is seen in IDLE. It falls in the same cycle the state enters IDLE.

## Structure
- Shared package `uart_pkg`:
  - Default `CLKDIV` constant.
  - `rx_state_t` enum {IDLE, START, DATA, STOP, BREAK}.
  - Frame constants: `DATA_BITS`=8 and start/stop levels.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with parameterized reset value 1.

## Test plan
- CLKDIV=433, send 0xA5 at the nominal rate -> exactly one `valid` pulse, `dout`=0xA5, `frame_err` never high.
- Low glitch of 100 cycles on an idle line -> return to IDLE. No `valid`, no `frame_err`. `busy` falls after the START sample (cycle 217).
- Frame 0x3C with the stop bit driven 0, line held low 2000 more cycles -> one `frame_err` pulse, `dout` keeps its prior value. BREAK is held until the line rises, and there is no spurious start.
- Back-to-back frames 0x55, 0xAA, 0x00, 0xFF with no idle gap, sender at +2% and then −2% baud -> four `valid` pulses with the correct bytes in order.
- Assert `rst` low during DATA bit 4 of 0x81 -> outputs return to reset values asynchronously. After release, the next frame 0x7E is received correctly.
- Loopback from the transmitter block, sweeping all 256 byte values -> every byte received unchanged, 256 `valid` pulses, 0 `frame_err`.
